writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-side initiator for the 32x32 register bank; owns the bank's single write port (we, sel_in, data_in).
- Merges a non-stallable fast producer (ALU commit, port A) with a stallable slow producer (load/mul, port B) into at most one write per cycle.
- Port B is buffered in a small FIFO. Write-after-write order to the same register is preserved.
- Starvation of port B is bounded by a registered stall request back to the pipeline.

Parameters:
- XLEN, 32, data width of register writes.
- DEPTH, 2, port-B FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 4, number of consecutive blocked cycles for the FIFO head before a_stall is asserted.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  fast-path write request; no backpressure.
- a_rd  in  5  fast-path destination register.
- a_data  in  XLEN  fast-path write data.
- a_stall  out  1  registered; upstream keeps a_valid=0 in any cycle where a_stall=1.
- b_valid  in  1  slow-path request.
- b_ready  out  1  slow-path accept; equals (count < DEPTH).
- b_rd  in  5  slow-path destination register.
- b_data  in  XLEN  slow-path write data.
- rf_we  out  1  register bank write enable.
- rf_sel_in  out  5  register bank write address.
- rf_data_in  out  XLEN  register bank write data.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, active-high) clears:
  - all outputs: rf_we=0, rf_sel_in=0, rf_data_in=0, a_stall=0, err=0, fifo_count=0;
  - FIFO pointers, kill bits and the starvation counter.
- Reset asserted mid-operation discards all queued B entries; no rf_we is produced in the cycle after reset.
- All rf_* outputs are registered.
  - Port A: request in cycle N appears on rf_* in cycle N+1 (latency 1).
  - Port B: accepted in cycle N, earliest rf_* in cycle N+2 (latency 2 minimum). The FIFO has no bypass.
- Port B handshake:
  - Push occurs when b_valid && b_ready.
  - When the FIFO is full, b_ready=0 even if a pop happens in the same cycle.
- Arbitration each cycle:
  - If a_stall=1 and the FIFO is non-empty: pop the head.
  - Else if a_valid=1: issue A.
  - Else if the FIFO is non-empty: pop the head.
  - Else: rf_we=0.
- Register x0: a write to rd=0 from either port is consumed, but rf_we=0 and rf_sel_in/rf_data_in keep their previous values.
- Write-after-write kill:
  - When A is issued with a_rd != 0, every valid FIFO entry with rd == a_rd sets its kill bit.
  - A B entry pushed in the same cycle is younger and is not killed.
  - Popping a killed entry consumes the slot and drives rf_we=0.
- Starvation counter:
  - Increments in each cycle where the FIFO is non-empty and A wins arbitration.
  - Clears on any pop, and when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, a_stall=1 for exactly the next cycle. The head pops in that cycle and the counter clears.
- a_valid=1 while a_stall=1 is a violation:
  - B still wins;
  - the A request is dropped;
  - err is set and stays set until reset.
- Pointers wrap modulo DEPTH. fifo_count is updated after push and pop in the same cycle: +1, -1 or 0.

Decomposition:
- Shared package, entries:
  - REG_ADDR_W=5;
  - X0 address constant;
  - typedef wb_req_t = {rd, data};
  - typedef fifo_entry_t = {wb_req_t, kill}.
- One sub-module: wb_fifo. It holds the DEPTH-entry circular buffer with a per-entry kill bit and a kill-by-rd input port.
- Arbitration, the starvation counter and the output registers stay in the top module.

Test Plan:
- Reset: reset=1 for 5 cycles with a_valid=1, a_rd=3 -> rf_we=0, fifo_count=0, b_ready=1 throughout; first write appears one cycle after reset falls.
- Fast path: a_valid with a_rd=5, a_data=0xDEADBEEF at cycle N -> rf_we=1, rf_sel_in=5, rf_data_in=0xDEADBEEF at N+1; a_rd=0 -> rf_we=0.
- FIFO full: push b_rd=1 then b_rd=2 while a_valid=1 every cycle -> fifo_count=2, b_ready=0. Drop a_valid -> rf_sel_in=1 then 2 on consecutive cycles; b_ready returns to 1.
- WAW kill: push b_rd=7, b_data=0x11 while A is busy, then A with a_rd=7, a_data=0x22 -> exactly one write to register 7, data 0x22; the later B pop gives rf_we=0.
- Starvation: one B entry queued, a_valid=1 continuously -> a_stall=1 in the cycle after 4 blocked cycles (STARVE_LIMIT=4); B data written in the cycle after that; a_stall returns to 0.
- Violation: a_valid=1 during a_stall -> B written, A dropped, err=1 stays set until reset.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared types and constants for the register-bank write-back path.
//   REG_ADDR_W   : width of a register-bank address (32 registers)
//   WB_XLEN      : data width carried by a queued write request
//   X0           : address of the hard-wired zero register
//   wb_req_t     : one pending write {rd, data}
//   fifo_entry_t : a queued write plus its write-after-write kill bit
// ----------------------------------------------------------------------------
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_XLEN    = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_req_t;

    typedef struct packed {
        wb_req_t req;
        logic    kill;
    } fifo_entry_t;

endpackage : writeback_arbiter_pkg

// File: rtl/writeback_arbiter_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry circular buffer for slow-path writes. Each entry carries a kill
// bit; a kill request marks every live entry whose rd matches kill_rd so that
// a younger fast-path write to the same register wins.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : write push_req at the tail (ignored when full)
//   push_req     : request to enqueue; always enters with kill = 0
//   pop          : drop the head entry (ignored when empty)
//   kill_en      : mark live entries with rd == kill_rd as killed
//   kill_rd      : register address to kill
//   head         : current head entry (valid when !empty)
//   count        : occupancy, 0..DEPTH
//   empty, full  : occupancy flags
// ----------------------------------------------------------------------------
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  wb_req_t                 push_req,
    input  logic                    pop,
    input  logic                    kill_en,
    input  logic [REG_ADDR_W-1:0]   kill_rd,
    output fifo_entry_t             head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          req_mem [DEPTH];
    logic [DEPTH-1:0] kill_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] offset;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] kill_hit;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head.req  = req_mem[rd_ptr];
    assign head.kill = kill_q[rd_ptr];

    // An entry is live when its distance from the head is below the occupancy.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        offset   = '0;
        live     = '0;
        kill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PTR_W'(i) - rd_ptr;
            live[i]     = ({1'b0, offset} < count);
            kill_hit[i] = kill_en && live[i] && (req_mem[i].rd == kill_rd);
        end
    end

    // NOTE: payload storage is deliberately not reset; the live window and the
    // kill bits decide what is meaningful, so clearing the array buys nothing.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            req_mem[wr_ptr] <= push_req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            kill_q <= '0;
        end else begin
            kill_q <= kill_q | kill_hit;
            if (push_ok) begin
                // The slot being written is not live, so the freshly pushed
                // (younger) entry starts un-killed.
                kill_q[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : wb_fifo

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Owns the register bank's single write port. Merges a non-stallable fast
// producer (port A, latency 1) with a buffered slow producer (port B, latency
// >= 2) into at most one write per cycle, preserving write-after-write order
// and bounding B starvation with a registered stall request.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   a_valid, a_rd, a_data   : fast-path write request (no backpressure)
//   a_stall                 : registered; upstream must hold a_valid = 0
//   b_valid, b_rd, b_data   : slow-path write request
//   b_ready                 : slow-path accept, (fifo_count < DEPTH)
//   rf_we, rf_sel_in,
//   rf_data_in              : registered register-bank write port
//   fifo_count              : port-B FIFO occupancy
//   err                     : sticky flag, a_valid seen while a_stall = 1
// ----------------------------------------------------------------------------
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int XLEN         = WB_XLEN,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_valid,
    input  logic [REG_ADDR_W-1:0]   a_rd,
    input  logic [XLEN-1:0]         a_data,
    output logic                    a_stall,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [REG_ADDR_W-1:0]   b_rd,
    input  logic [XLEN-1:0]         b_data,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_sel_in,
    output logic [XLEN-1:0]         rf_data_in,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    fifo_entry_t         head;
    wb_req_t             b_req;
    logic                fifo_empty;
    logic                fifo_full;
    logic                b_push;
    logic                issue_a;
    logic                pop_head;
    logic                kill_en;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_next;

    assign b_ready    = !fifo_full;
    assign b_push     = b_valid && b_ready;
    assign b_req.rd   = b_rd;
    assign b_req.data = b_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (b_push),
        .push_req (b_req),
        .pop      (pop_head),
        .kill_en  (kill_en),
        .kill_rd  (a_rd),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // A stall cycle always belongs to the FIFO head; an A request arriving
    // during a stall is a protocol violation and is simply dropped.
    always_comb begin
        issue_a     = a_valid && !a_stall;
        pop_head    = !fifo_empty && (a_stall || !a_valid);
        kill_en     = issue_a && (a_rd != X0);
        starve_next = starve_q;
        if (pop_head || fifo_empty) begin
            starve_next = '0;
        end else if (issue_a && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_next = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
            a_stall  <= 1'b0;
            err      <= 1'b0;
        end else begin
            starve_q <= starve_next;
            a_stall  <= (starve_next == STARVE_W'(STARVE_LIMIT));
            if (a_valid && a_stall) begin
                err <= 1'b1;
            end
        end
    end

    // Writes to x0 and killed entries consume their slot but leave the
    // address/data registers untouched with rf_we low.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_sel_in  <= '0;
            rf_data_in <= '0;
        end else begin
            rf_we <= 1'b0;
            if (issue_a) begin
                if (a_rd != X0) begin
                    rf_we      <= 1'b1;
                    rf_sel_in  <= a_rd;
                    rf_data_in <= a_data;
                end
            end else if (pop_head) begin
                if (!head.kill && (head.req.rd != X0)) begin
                    rf_we      <= 1'b1;
                    rf_sel_in  <= head.req.rd;
                    rf_data_in <= XLEN'(head.req.data);
                end
            end
        end
    end

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed scenarios with literal expectations, then randomized traffic. A
// queue-based reference model tracks the expected write port, FIFO occupancy,
// stall and error flags; a negedge process compares the DUT against it.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int XLEN         = 32;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             a_valid = 1'b0;
    logic [4:0]       a_rd = '0;
    logic [XLEN-1:0]  a_data = '0;
    logic             a_stall;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [4:0]       b_rd = '0;
    logic [XLEN-1:0]  b_data = '0;
    logic             rf_we;
    logic [4:0]       rf_sel_in;
    logic [XLEN-1:0]  rf_data_in;
    logic [1:0]       fifo_count;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;

    writeback_arbiter #(
        .XLEN         (XLEN),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .a_stall    (a_stall),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .rf_we      (rf_we),
        .rf_sel_in  (rf_sel_in),
        .rf_data_in (rf_data_in),
        .fifo_count (fifo_count),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            kill;
    } m_ent_t;

    m_ent_t          q[$];
    m_ent_t          h;
    int              m_starve = 0;
    bit              m_stall  = 0;
    bit              m_err    = 0;
    bit              m_we     = 0;
    logic [4:0]      m_sel    = '0;
    logic [XLEN-1:0] m_data   = '0;
    bit              had_entries, a_wins, b_wins, can_push;

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            m_starve = 0;
            m_stall  = 0;
            m_err    = 0;
            m_we     = 0;
            m_sel    = '0;
            m_data   = '0;
        end else begin
            had_entries = (q.size() > 0);
            can_push    = (q.size() < DEPTH);
            a_wins      = a_valid && !m_stall;
            b_wins      = had_entries && !a_wins;
            if (a_valid && m_stall) m_err = 1;
            m_we = 0;
            if (a_wins) begin
                if (a_rd != 0) begin
                    m_we   = 1;
                    m_sel  = a_rd;
                    m_data = a_data;
                    foreach (q[i]) if (q[i].rd == a_rd) q[i].kill = 1'b1;
                end
            end else if (b_wins) begin
                h = q.pop_front();
                if (!h.kill && h.rd != 0) begin
                    m_we   = 1;
                    m_sel  = h.rd;
                    m_data = h.data;
                end
            end
            if (b_valid && can_push) q.push_back('{rd: b_rd, data: b_data, kill: 1'b0});
            if (b_wins || !had_entries) m_starve = 0;
            else if (a_wins)            m_starve++;
            m_stall = (m_starve == STARVE_LIMIT);
        end
    end

    always @(negedge clock) begin
        check("rf_we",      64'(rf_we),      64'(m_we));
        check("rf_sel_in",  64'(rf_sel_in),  64'(m_sel));
        check("rf_data_in", 64'(rf_data_in), 64'(m_data));
        check("a_stall",    64'(a_stall),    64'(m_stall));
        check("err",        64'(err),        64'(m_err));
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
        check("b_ready",    64'(b_ready),    64'(q.size() < DEPTH));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [4:0] br, input logic [XLEN-1:0] bd);
        a_valid = av;  a_rd = ar;  a_data = ad;
        b_valid = bv;  b_rd = br;  b_data = bd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        logic            av, bv;
        logic [4:0]      ar, br;
        logic [XLEN-1:0] ad, bd;

        // Reset held with A traffic: nothing may be written.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0);
            check("rst_we", 64'(rf_we), 64'd0);
            check("rst_count", 64'(fifo_count), 64'd0);
            check("rst_b_ready", 64'(b_ready), 64'd1);
        end
        reset = 1'b0;
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0);
        check("post_rst_we", 64'(rf_we), 64'd1);
        check("post_rst_sel", 64'(rf_sel_in), 64'd3);

        // Fast path and x0 suppression.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        check("a_we", 64'(rf_we), 64'd1);
        check("a_sel", 64'(rf_sel_in), 64'd5);
        check("a_data", 64'(rf_data_in), 64'hDEADBEEF);
        cyc(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, '0);
        check("a_x0_we", 64'(rf_we), 64'd0);
        check("a_x0_hold", 64'(rf_data_in), 64'hDEADBEEF);

        // Fill the FIFO behind A, then drain it.
        cyc(1'b1, 5'd9, 32'h9, 1'b1, 5'd1, 32'hB1);
        check("full_cnt1", 64'(fifo_count), 64'd1);
        cyc(1'b1, 5'd9, 32'h9, 1'b1, 5'd2, 32'hB2);
        check("full_cnt2", 64'(fifo_count), 64'd2);
        check("full_ready", 64'(b_ready), 64'd0);
        idle();
        check("drain1_sel", 64'(rf_sel_in), 64'd1);
        check("drain1_data", 64'(rf_data_in), 64'hB1);
        check("drain1_ready", 64'(b_ready), 64'd1);
        idle();
        check("drain2_sel", 64'(rf_sel_in), 64'd2);
        check("drain2_data", 64'(rf_data_in), 64'hB2);

        // Write-after-write kill.
        cyc(1'b1, 5'd10, 32'hA, 1'b1, 5'd7, 32'h11);
        cyc(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, '0);
        check("waw_a_sel", 64'(rf_sel_in), 64'd7);
        check("waw_a_data", 64'(rf_data_in), 64'h22);
        idle();
        check("waw_kill_we", 64'(rf_we), 64'd0);
        check("waw_kill_data", 64'(rf_data_in), 64'h22);
        check("waw_kill_cnt", 64'(fifo_count), 64'd0);

        // Starvation: four blocked cycles raise a_stall for one cycle.
        cyc(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC0FFEE);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            cyc(1'b1, 5'd13, 32'(i), 1'b0, 5'd0, '0);
            check("starve_stall", 64'(a_stall), 64'(i == STARVE_LIMIT - 1));
        end
        idle();
        check("starve_we", 64'(rf_we), 64'd1);
        check("starve_sel", 64'(rf_sel_in), 64'd12);
        check("starve_data", 64'(rf_data_in), 64'hC0FFEE);
        check("starve_release", 64'(a_stall), 64'd0);

        // Violation: A driven during a_stall is dropped and err sticks.
        cyc(1'b1, 5'd11, 32'hB, 1'b1, 5'd14, 32'hE14);
        for (int i = 0; i < STARVE_LIMIT; i++) cyc(1'b1, 5'd13, 32'(i), 1'b0, 5'd0, '0);
        check("viol_stall", 64'(a_stall), 64'd1);
        cyc(1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, '0);
        check("viol_b_sel", 64'(rf_sel_in), 64'd14);
        check("viol_b_data", 64'(rf_data_in), 64'hE14);
        check("viol_err", 64'(err), 64'd1);
        cyc(1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, '0);
        check("viol_a_after", 64'(rf_sel_in), 64'd15);
        check("viol_err_sticky", 64'(err), 64'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("viol_err_clr", 64'(err), 64'd0);

        // B write to x0 is consumed silently.
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hAA);
        idle();
        check("b_x0_we", 64'(rf_we), 64'd0);
        check("b_x0_data", 64'(rf_data_in), 64'd0);
        check("b_x0_cnt", 64'(fifo_count), 64'd0);

        // Randomized traffic over a small register set to provoke kills.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            av = ($urandom_range(0, 99) < 65);
            if (m_stall && $urandom_range(0, 39) != 0) av = 1'b0;
            bv = ($urandom_range(0, 99) < 50);
            ar = 5'($urandom_range(0, 3));
            br = 5'($urandom_range(0, 3));
            ad = $urandom;
            bd = $urandom;
            cyc(av, ar, ad, bv, br, bd);
        end
        reset = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_writeback_arbiter
